// File: rtl/sobel_frame_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sobel_frame_scheduler_if : config, run control and pipeline status bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface sobel_frame_scheduler_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DATA_WIDTH-1:0] cfg_thresh;
  logic [7:0]            cfg_frames;
  logic                  run;
  logic                  abort;
  logic [15:0]           in_xres;
  logic [15:0]           in_yres;
  logic                  src_begin;
  logic                  src_done;
  logic                  post_vsync;
  logic                  post_valid;
  logic [DATA_WIDTH-1:0] thresh;
  logic                  busy;
  logic [7:0]            frame_cnt;
  logic                  run_done;
  logic                  err_timeout;
  logic                  err_pixcnt;

  modport master (
    output cfg_valid, cfg_thresh, cfg_frames, run, abort, in_xres, in_yres,
           src_done, post_vsync, post_valid,
    input  cfg_ready, src_begin, thresh, busy, frame_cnt, run_done,
           err_timeout, err_pixcnt
  );

  modport slave (
    input  cfg_valid, cfg_thresh, cfg_frames, run, abort, in_xres, in_yres,
           src_done, post_vsync, post_valid,
    output cfg_ready, src_begin, thresh, busy, frame_cnt, run_done,
           err_timeout, err_pixcnt
  );
endinterface
`default_nettype wire

// File: rtl/sobel_frame_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sobel_frame_scheduler : sequences source start / sink completion per frame
// Revision 1.0
// ---------------------------------------------------------------------------
module sobel_frame_scheduler #(
  parameter int DATA_WIDTH  = 8,
  parameter int START_PULSE = 5,
  parameter int GAP_CYCLES  = 16,
  parameter int TIMEOUT_CYC = 700000
) (
  input wire logic               clk,
  input wire logic               rst,
  sobel_frame_scheduler_if.slave ctl
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [DATA_WIDTH-1:0] THRESH_RST = DATA_WIDTH'(127);
  localparam logic [31:0] PULSE_LAST = 32'(START_PULSE - 1);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] WD_LAST    = 32'(TIMEOUT_CYC - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] shadow;
  logic [DATA_WIDTH-1:0] thresh_q;
  logic                  pending;
  logic                  cfg_ready_q;
  logic [7:0]            frames_tgt;
  logic [7:0]            frame_cnt_q;
  logic [31:0]           exp_pix;
  logic [31:0]           pix_cnt;
  logic [31:0]           wd_cnt;
  logic [31:0]           step_cnt;
  logic                  src_seen;
  logic                  sink_seen;
  logic                  vsync_q;
  logic                  src_begin_q;
  logic                  busy_q;
  logic                  run_done_q;
  logic                  err_to_q;
  logic                  err_pix_q;

  logic        cfg_hs;
  logic        vs_fall;
  logic        frame_end;
  logic        last_frame;
  logic        wd_expire;
  logic        gap_end;
  logic        start_entry;
  logic [7:0]  fc_next;
  logic [31:0] pix_next;

  // Same-cycle src_done / vsync fall and the final post_valid are folded in here.
  always_comb begin
    cfg_hs      = ctl.cfg_valid & cfg_ready_q;
    vs_fall     = vsync_q & ~ctl.post_vsync;
    pix_next    = (ctl.post_valid && (pix_cnt != '1)) ? pix_cnt + 32'd1 : pix_cnt;
    fc_next     = frame_cnt_q + 8'd1;
    frame_end   = (state == WAIT) && (src_seen | ctl.src_done) && (sink_seen | vs_fall);
    last_frame  = (frames_tgt != 8'd0) && (fc_next == frames_tgt);
    wd_expire   = ((state == START) || (state == WAIT)) && (wd_cnt >= WD_LAST);
    gap_end     = (state == GAP) && (step_cnt >= GAP_LAST);
    start_entry = !ctl.abort &&
                  (((state == IDLE) && ctl.run) || gap_end ||
                   (frame_end && !last_frame && (GAP_CYCLES == 0)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shadow      <= THRESH_RST;
      thresh_q    <= THRESH_RST;
      pending     <= 1'b0;
      cfg_ready_q <= 1'b1;
      frames_tgt  <= 8'd0;
      frame_cnt_q <= 8'd0;
      exp_pix     <= 32'd0;
      pix_cnt     <= 32'd0;
      wd_cnt      <= 32'd0;
      step_cnt    <= 32'd0;
      src_seen    <= 1'b0;
      sink_seen   <= 1'b0;
      vsync_q     <= 1'b0;
      src_begin_q <= 1'b0;
      busy_q      <= 1'b0;
      run_done_q  <= 1'b0;
      err_to_q    <= 1'b0;
      err_pix_q   <= 1'b0;
    end else begin
      vsync_q    <= ctl.post_vsync;
      run_done_q <= 1'b0;

      // A pending threshold lands only while idle or on a frame start.
      if (cfg_hs) begin
        shadow      <= ctl.cfg_thresh;
        pending     <= 1'b1;
        cfg_ready_q <= 1'b0;
      end else if (pending && ((state == IDLE) || start_entry)) begin
        thresh_q    <= shadow;
        pending     <= 1'b0;
        cfg_ready_q <= 1'b1;
      end

      if ((state == START) || (state == WAIT)) begin
        wd_cnt  <= wd_cnt + 32'd1;
        pix_cnt <= pix_next;
        if (vs_fall) sink_seen <= 1'b1;
      end
      if ((state == WAIT) && ctl.src_done) src_seen <= 1'b1;

      if (ctl.abort) begin
        state       <= IDLE;
        src_begin_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ctl.run) begin
              frame_cnt_q <= 8'd0;
              err_to_q    <= 1'b0;
              err_pix_q   <= 1'b0;
              exp_pix     <= 32'(ctl.in_xres) * 32'(ctl.in_yres);
              frames_tgt  <= ctl.cfg_frames;
              busy_q      <= 1'b1;
            end
          end
          START: begin
            if (wd_expire) begin
              err_to_q    <= 1'b1;
              src_begin_q <= 1'b0;
              run_done_q  <= 1'b1;
              state       <= DONE;
            end else if (step_cnt >= PULSE_LAST) begin
              src_begin_q <= 1'b0;
              state       <= WAIT;
            end else begin
              step_cnt <= step_cnt + 32'd1;
            end
          end
          WAIT: begin
            if (frame_end) begin
              if (pix_next != exp_pix) err_pix_q <= 1'b1;
              frame_cnt_q <= fc_next;
              if (last_frame) begin
                run_done_q <= 1'b1;
                state      <= DONE;
              end else if (GAP_CYCLES != 0) begin
                step_cnt <= 32'd0;
                state    <= GAP;
              end
            end else if (wd_expire) begin
              err_to_q   <= 1'b1;
              run_done_q <= 1'b1;
              state      <= DONE;
            end
          end
          GAP: begin
            if (!gap_end) step_cnt <= step_cnt + 32'd1;
          end
          DONE: begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase

        if (start_entry) begin
          state       <= START;
          src_begin_q <= 1'b1;
          step_cnt    <= 32'd0;
          wd_cnt      <= 32'd0;
          pix_cnt     <= 32'd0;
          src_seen    <= 1'b0;
          sink_seen   <= 1'b0;
        end
      end
    end
  end

  assign ctl.cfg_ready   = cfg_ready_q;
  assign ctl.src_begin   = src_begin_q;
  assign ctl.thresh      = thresh_q;
  assign ctl.busy        = busy_q;
  assign ctl.frame_cnt   = frame_cnt_q;
  assign ctl.run_done    = run_done_q;
  assign ctl.err_timeout = err_to_q;
  assign ctl.err_pixcnt  = err_pix_q;
endmodule
`default_nettype wire
